// File: rtl/pwm_ramp_pkg.sv
// Shared helpers for pwm_ramp_bank: command clamp, slew step and pulse-width
// calculation, plus the sizing rule for the internal signed width registers.
// All arithmetic runs on 32-bit signed ints so no intermediate truncates.
package pwm_ramp_pkg;

  // Extra bits over $clog2(PERIOD_TICKS): one for the value PERIOD_TICKS itself,
  // one for the sign.
  localparam int WIDTH_GUARD = 2;

  function automatic int width_bits(input int period);
    return $clog2(period) + WIDTH_GUARD;
  endfunction

  // Symmetric magnitude clamp; the most negative input clamps like any other.
  function automatic int clamp_cmd(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Move cur toward tgt by at most slew; lands exactly on tgt, never overshoots.
  function automatic int slew_step(input int cur, input int tgt, input int slew);
    int diff;
    diff = tgt - cur;
    if (diff > slew)  diff = slew;
    if (diff < -slew) diff = -slew;
    return cur + diff;
  endfunction

  // Pulse width for an applied command, after the optional mirror flip.
  function automatic int calc_width(input int cur, input bit flip, input int zero,
                                    input int scale);
    int eff;
    eff = flip ? -cur : cur;
    return zero + eff * scale;
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: holds the applied command (cur) and pulse width, updates them
// at frame boundaries, and registers the compare output on every tick.
// Ports:
//   clk, reset     clock, async active-high reset
//   enable_i       run/stop; low clears the channel to its rest state
//   tick_i         count strobe
//   frame_i        this tick is a frame boundary
//   count_next_i   counter value after this tick
//   cmd_i          signed target command
//   pwm_o          registered PWM output
//   cur_o          applied command (pre-flip)
module pwm_ramp_channel
  import pwm_ramp_pkg::*;
#(
  parameter int CMD_W        = 8,
  parameter int PERIOD_TICKS = 20000,
  parameter int ZERO_TICKS   = 1500,
  parameter int SCALE        = 4,
  parameter int CMD_MAX      = 100,
  parameter int SLEW         = 2,
  parameter bit FLIP         = 1'b0,
  parameter int CNT_W        = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             tick_i,
  input  logic             frame_i,
  input  logic [CNT_W-1:0] count_next_i,
  input  logic [CMD_W-1:0] cmd_i,
  output logic             pwm_o,
  output logic [CMD_W-1:0] cur_o
);
  localparam int WW = width_bits(PERIOD_TICKS);

  logic signed [CMD_W-1:0] cur_q, cur_d;
  logic signed [WW-1:0]    width_q, width_d;
  logic                    pwm_q, pwm_d;
  int                      tgt, cur_new, width_new;

  assign tgt       = clamp_cmd(int'($signed(cmd_i)), CMD_MAX);
  assign cur_new   = slew_step(int'(cur_q), tgt, SLEW);
  assign width_new = calc_width(cur_new, FLIP, ZERO_TICKS, SCALE);

  always_comb begin
    cur_d   = cur_q;
    width_d = width_q;
    pwm_d   = pwm_q;
    if (!enable_i) begin
      cur_d   = '0;
      width_d = WW'(ZERO_TICKS);
      pwm_d   = 1'b0;
    end else if (tick_i) begin
      if (frame_i) begin
        cur_d   = CMD_W'(cur_new);
        width_d = WW'(width_new);
      end
      // Compare against next-state values so a new frame opens with its new width.
      pwm_d = int'(count_next_i) < int'(width_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      width_q <= WW'(ZERO_TICKS);
      pwm_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
  assign cur_o = cur_q;

endmodule

// File: rtl/pwm_ramp_bank.sv
// Multi-channel slew-limited servo PWM generator. One shared frame counter
// advanced by tick; each channel clamps and ramps its command once per frame.
// Ports:
//   clk, reset     clock, async active-high reset
//   tick           single-cycle count strobe
//   enable         run/stop; low parks the counter at end of frame
//   cmd_in         packed signed targets, channel i at [i*CMD_W +: CMD_W]
//   pwm_out        registered PWM outputs
//   cur_cmd        packed applied commands (after clamp/slew, before flip)
//   frame_start    one-cycle pulse per frame boundary
module pwm_ramp_bank
  import pwm_ramp_pkg::*;
#(
  parameter int                  CHANNELS     = 2,
  parameter int                  CMD_W        = 8,
  parameter int                  PERIOD_TICKS = 20000,
  parameter int                  ZERO_TICKS   = 1500,
  parameter int                  SCALE        = 4,
  parameter int                  CMD_MAX      = 100,
  parameter int                  SLEW         = 2,
  parameter logic [CHANNELS-1:0] FLIP_MASK    = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      enable,
  input  logic [CHANNELS*CMD_W-1:0] cmd_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*CMD_W-1:0] cur_cmd,
  output logic                      frame_start
);
  localparam int              CNT_W = $clog2(PERIOD_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_TICKS - 1);

  if (ZERO_TICKS < CMD_MAX * SCALE ||
      ZERO_TICKS + CMD_MAX * SCALE > PERIOD_TICKS) begin : g_bad_params
    $error("pwm_ramp_bank: pulse width range does not fit inside the frame");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_q, boundary;

  assign boundary = enable && tick && (count_q == LAST);

  // Disabled: park at LAST so the first tick after re-enable opens a frame.
  always_comb begin
    count_d = count_q;
    if (!enable)   count_d = LAST;
    else if (tick) count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= LAST;
      frame_q <= 1'b0;
    end else begin
      count_q <= count_d;
      frame_q <= boundary;
    end
  end

  assign frame_start = frame_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_ramp_channel #(
      .CMD_W(CMD_W), .PERIOD_TICKS(PERIOD_TICKS), .ZERO_TICKS(ZERO_TICKS),
      .SCALE(SCALE), .CMD_MAX(CMD_MAX), .SLEW(SLEW), .FLIP(FLIP_MASK[i]),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .enable_i     (enable),
      .tick_i       (tick),
      .frame_i      (boundary),
      .count_next_i (count_d),
      .cmd_i        (cmd_in[i*CMD_W +: CMD_W]),
      .pwm_o        (pwm_out[i]),
      .cur_o        (cur_cmd[i*CMD_W +: CMD_W])
    );
  end

endmodule
